// File: rtl/state_sequencer.sv
// Table-driven state sequencer: a prescaler tick steps an index through one of two
// writable tables. Optional `STATE_SEQ_STEP_EN adds single-step advance while held.
module state_sequencer #(
    parameter int unsigned CLOCK = 12000000,
    parameter int unsigned WIDTH = 3,
    parameter int unsigned DEPTH = 8,
    localparam int unsigned AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             CR,
    input  logic             M,
    input  logic             run,
    input  logic             step,
    input  logic             wr_en,
    input  logic             wr_sel,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] data,
    output logic [AW-1:0]    idx,
    output logic             tick,
    output logic             wrap
);

    localparam int unsigned TW = (CLOCK > 1) ? $clog2(CLOCK) : 1;

    logic [TW-1:0]    timer, timer_n;
    logic             mode, mode_n;
    logic [WIDTH-1:0] tbl [2][DEPTH];
    logic [AW-1:0]    idx_n;
    logic [WIDTH-1:0] data_n;
    logic             wrap_n;
    logic             adv_c, chg_c, sel_c, wr_ok_c, last_c;

`ifdef STATE_SEQ_STEP_EN
    logic step_d, step_dd;

    always_ff @(posedge clk) begin
        if (CR) begin
            step_d  <= 1'b0;
            step_dd <= 1'b0;
        end else begin
            step_d  <= step;
            step_dd <= step_d;
        end
    end
`else
    logic unused_step;
    assign unused_step = step;
`endif

    // Prescaler, advance decision and next output values
    always_comb begin
        timer_n = timer;
        adv_c   = 1'b0;
        mode_n  = mode;
        idx_n   = idx;
        data_n  = data;
        wrap_n  = 1'b0;
        if (run) begin
            if (timer == TW'(CLOCK - 1)) begin
                timer_n = '0;
                adv_c   = 1'b1;
            end else begin
                timer_n = timer + TW'(1);
            end
        end
`ifdef STATE_SEQ_STEP_EN
        else if (step_d && !step_dd) begin
            adv_c = 1'b1;
        end
`endif
        wr_ok_c = wr_en && (32'(wr_addr) < DEPTH);
        chg_c   = (M != mode);
        sel_c   = chg_c ? M : mode;
        last_c  = (idx == AW'(DEPTH - 1));
        if (adv_c) begin
            if (chg_c) begin
                mode_n = M;
                idx_n  = '0;
            end else begin
                idx_n  = last_c ? '0 : idx + AW'(1);
                wrap_n = last_c;
            end
            // Same-cycle write to the entry being loaded is forwarded
            if (wr_ok_c && (wr_sel == sel_c) && (wr_addr == idx_n))
                data_n = wr_data;
            else
                data_n = tbl[sel_c][idx_n];
        end
    end

    always_ff @(posedge clk) begin
        if (CR) begin
            timer <= '0;
            mode  <= 1'b0;
            idx   <= '0;
            data  <= '1;
            tick  <= 1'b0;
            wrap  <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                tbl[0][i] <= WIDTH'(DEPTH - 1 - i);
                tbl[1][i] <= WIDTH'(i);
            end
        end else begin
            timer <= timer_n;
            mode  <= mode_n;
            idx   <= idx_n;
            data  <= data_n;
            tick  <= adv_c;
            wrap  <= wrap_n;
            if (wr_ok_c)
                tbl[wr_sel][wr_addr] <= wr_data;
        end
    end

endmodule

// File: tb/tb_state_sequencer.sv
// Scoreboard bench for state_sequencer: a behavioural model queues expected
// advances/resets; a monitor checks every edge against the queue.
module tb_state_sequencer;

    localparam int unsigned CLK_P = 4;
    localparam int unsigned W     = 3;
    localparam int unsigned D     = 8;
    localparam int unsigned AW    = 3;

    logic          clk = 1'b0;
    logic          CR = 1'b1, M = 1'b0, run = 1'b0, step = 1'b0;
    logic          wr_en = 1'b0, wr_sel = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [W-1:0]  wr_data = '0;
    logic [W-1:0]  data;
    logic [AW-1:0] idx;
    logic          tick, wrap;

    state_sequencer #(.CLOCK(CLK_P), .WIDTH(W), .DEPTH(D)) dut (
        .clk(clk), .CR(CR), .M(M), .run(run), .step(step),
        .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr), .wr_data(wr_data),
        .data(data), .idx(idx), .tick(tick), .wrap(wrap)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned cyc;
        int          tck;
        int          idx;
        int          data;
        int          wrp;
    } exp_t;

    exp_t        q[$];
    int unsigned cyc   = 0;
    int unsigned tests = 0;
    int unsigned fails = 0;

    // Behavioural model: running-cycle count, position, mode and table contents
    int m_cnt = 0, m_idx = 0, m_mode = 0;
    int m_tbl [2][D];
    bit sp1 = 0, sp2 = 0;
    bit cur_m = 0, cur_run = 0;

    task automatic chk(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s cyc=%0d got=%0d exp=%0d", name, cyc, got, exp);
        end
    endtask

    task automatic drive(input bit cr, input bit m, input bit r, input bit s,
                         input bit we, input bit ws, input int wa, input int wd);
        exp_t e;
        bit   adv;
        CR = cr; M = m; run = r; step = s;
        wr_en = we; wr_sel = ws; wr_addr = AW'(wa); wr_data = W'(wd);
        adv = 0;
        if (cr) begin
            m_cnt = 0; m_idx = 0; m_mode = 0; sp1 = 0; sp2 = 0;
            for (int i = 0; i < D; i++) begin
                m_tbl[0][i] = (D - 1 - i) % (1 << W);
                m_tbl[1][i] = i % (1 << W);
            end
            e = '{cyc + 1, 0, 0, (1 << W) - 1, 0};
            q.push_back(e);
        end else begin
            if (r) begin
                if (m_cnt == CLK_P - 1) begin
                    m_cnt = 0;
                    adv = 1;
                end else begin
                    m_cnt++;
                end
            end
`ifdef STATE_SEQ_STEP_EN
            else if (sp1 && !sp2) adv = 1;
            sp2 = sp1;
            sp1 = s;
`endif
            if (we) m_tbl[ws][wa] = wd;
            if (adv) begin
                e.wrp = 0;
                if (int'(m) != m_mode) begin
                    m_mode = int'(m);
                    m_idx = 0;
                end else begin
                    e.wrp = (m_idx == D - 1) ? 1 : 0;
                    m_idx = (m_idx + 1) % D;
                end
                e.cyc = cyc + 1; e.tck = 1; e.idx = m_idx;
                e.data = m_tbl[m_mode][m_idx];
                q.push_back(e);
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(0, cur_m, cur_run, 0, 0, 0, 0, 0);
    endtask

    // Idle until the model reaches the given position (-1 = don't care)
    task automatic wait_state(input int wi, input int wm, input int wc);
        int k;
        k = 0;
        while (k < 200 && !((wi < 0 || m_idx == wi) && (wm < 0 || m_mode == wm) &&
                            (wc < 0 || m_cnt == wc))) begin
            idle(1);
            k++;
        end
        chk("wait_state_reached", (k < 200) ? 1 : 0, 1);
    endtask

    // Monitor: each edge either consumes a due expectation or must hold outputs
    initial begin
        exp_t e;
        int   h_idx, h_data;
        bit   have;
        have = 0; h_idx = 0; h_data = 0;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (q.size() > 0 && q[0].cyc == cyc) begin
                e = q.pop_front();
                chk("tick", int'(tick), e.tck);
                chk("idx", int'(idx), e.idx);
                chk("data", int'(data), e.data);
                chk("wrap", int'(wrap), e.wrp);
                h_idx = e.idx; h_data = e.data; have = 1;
            end else if (have) begin
                chk("tick_idle", int'(tick), 0);
                chk("wrap_idle", int'(wrap), 0);
                chk("idx_hold", int'(idx), h_idx);
                chk("data_hold", int'(data), h_data);
            end
        end
    end

    initial begin
        // Reset, first tick, wrap through mode 0
        cur_m = 0; cur_run = 0;
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        cur_run = 1;
        idle(40);
        // Mode switch at idx 3
        wait_state(3, 0, -1);
        cur_m = 1;
        idle(14);
        // Write-through on the 1->2 advance, later revisit, write under a held entry
        cur_m = 0;
        wait_state(1, 0, CLK_P - 1);
        drive(0, 0, 1, 0, 1, 0, 2, 5);
        idle(36);
        wait_state(2, 0, 0);
        drive(0, 0, 1, 0, 1, 0, 2, 3);
        idle(8);
        // Hold at timer 2, step pulse while held
        wait_state(-1, -1, 2);
        cur_run = 0;
        idle(4);
        drive(0, 0, 0, 1, 0, 0, 0, 0);
        drive(0, 0, 0, 1, 0, 0, 0, 0);
        idle(4);
        cur_run = 1;
        idle(6);
        // Reset with a write pending and a tick due
        wait_state(-1, -1, CLK_P - 1);
        drive(1, 0, 1, 0, 1, 0, 0, 2);
        idle(40);
        // Randomised traffic
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(49) == 0) cur_m = ~cur_m;
            cur_run = ($urandom_range(9) < 8);
            drive($urandom_range(99) == 0, cur_m, cur_run, $urandom_range(3) == 0,
                  $urandom_range(7) == 0, 1'($urandom_range(1)),
                  int'($urandom_range(D - 1)), int'($urandom_range(7)));
        end
        idle(3);
        chk("queue_drained", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/state_sequencer.md
# state_sequencer

Parametrised, table-driven state sequence generator: a prescaler derives a one-cycle advance tick from `clk`, and each tick steps an index through one of two programmable sequence tables (selected by `M`), presenting the current entry on `data`. It is the next-generation replacement for the fixed 3-bit, two-mode light/state sequencer used in the board-level demos. It generalises output width, sequence depth and tick period; adds runtime table loading, run/hold control and wrap reporting; and is fully synchronous, with no derived clocks.

## Interface
- `CLOCK`, default 12000000: prescaler period in `clk` cycles (≥1); 1 s tick at 12 MHz.
- `WIDTH`, default 3: bits per sequence entry / `data` width (≥1).
- `DEPTH`, default 8: entries per table (≥2); `AW = $clog2(DEPTH)`.
- `clk` in 1: the single clock.
- `CR` in 1: reset, synchronous and active-high.
- `M` in 1: mode select; 0 = table 0, 1 = table 1.
- `run` in 1: 1 = prescaler counts and ticks advance; 0 = hold.
- `step` in 1: single-step request, used only with `STATE_SEQ_STEP_EN`.
- `wr_en` in 1: table write strobe.
- `wr_sel` in 1: table written (0/1).
- `wr_addr` in AW: entry index written.
- `wr_data` in WIDTH: entry value.
- `data` out WIDTH: current sequence entry, registered.
- `idx` out AW: current index, registered.
- `tick` out 1: one-cycle pulse on every advance.
- `wrap` out 1: one-cycle pulse when `idx` goes DEPTH-1→0 by normal advance.

## Operation
- Reset (`CR`=1 at an edge): timer=0, `idx`=0, mode register=0, `tick`=0, `wrap`=0, `data`=all ones. Table 0 entry i = (DEPTH-1-i) mod 2^WIDTH. Table 1 entry i = i mod 2^WIDTH. `CR` overrides every other input, including writes in the same cycle.
- Prescaler: when `run`=1, timer counts 0..CLOCK-1. On the edge where timer==CLOCK-1: timer←0 and an advance event occurs. When `run`=0, timer holds its value; it is not cleared.
- Advance event, if `M` ≠ mode register: mode←`M`, `idx`←0, `data`←table[`M`][0], `wrap`=0. A mode change always restarts the sequence.
- Advance event, otherwise: `idx`←(`idx`==DEPTH-1 ? 0 : `idx`+1), `data`←table[mode][next idx]. `wrap`=1 on the 0 case.
- `M` changes between ticks have no effect until the next advance.
- Write: when `wr_en`=1, table[`wr_sel`][`wr_addr`]←`wr_data` at the edge. `wr_addr` ≥ DEPTH is ignored.
- Writes never alter `data` directly. The exception is an advance that loads the entry being written in the same cycle: `data` takes `wr_data` (write-through bypass).

## Timing
- All outputs are registered. `tick`, `idx`, `data` and `wrap` update on the same edge.
- First advance occurs CLOCK edges after `CR` deasserts with `run`=1. Thereafter there is exactly one advance per CLOCK running cycles.
- CLOCK=1: advance on every running edge, `tick` held high continuously.
- Pausing `run` for k cycles delays the next tick by exactly k cycles.
- `CR` asserted mid-count: the next edge applies the reset values. A pending tick is discarded.

## Configuration
- `STATE_SEQ_STEP_EN` defined:
  - When `run`=0, a rising edge of `step` (registered 0→1) produces one advance event on the following edge, with identical rules including `tick` and `wrap`. The timer is untouched.
  - `step` is ignored while `run`=1.
- Not defined: `step` is ignored entirely; no edge-detect register is built.

## Test plan
Bench parameters: CLOCK=4, WIDTH=3, DEPTH=8.
- Reset/first tick: `CR` 2 cycles, then `run`=1, `M`=0 → `data`=7, `idx`=0 until edge 4 after release. Then `tick`=1 for 1 cycle, `data`=6, `idx`=1.
- Wrap: run 8 ticks in mode 0 → `data` 7,6,…,0,7; `wrap` high only with the 0→7 step, `idx`=0.
- Mode switch: at `idx`=3 set `M`=1 → next tick `idx`=0, `data`=0, `wrap`=0; following ticks give `data` 1, 2.
- Table write with bypass: write table0[2]=5 at the same edge as the advance from `idx` 1→2 → `data`=5. A later visit to entry 2 also shows 5. Writing table0[2]=3 while `idx`=2 leaves `data`=5.
- Hold: `run`=0 for 10 cycles at timer=2 → no `tick`. `run`=1 → tick 2 cycles later. With `STATE_SEQ_STEP_EN`, a `step` pulse while held advances `idx` by exactly 1. Without the macro, nothing changes.
- Mid-operation reset: `CR` pulsed one cycle at timer=3 with `wr_en`=1 → no tick, the write is lost, `data`=7, `idx`=0, and table contents revert to defaults.
